div_unit: RTL and testbench

Multi-cycle 32-bit divider executing MIPS DIV/DIVU and writing the HI/LO pair. It sits directly downstream of the leading-zero counter: the divider drives the counter's data input with the registered dividend magnitude and reads back its count. The count lets the divider skip iterations for leading zero bits. The EX stage stalls on `busy` and captures `hi`/`lo` on `done`.

---
 rtl/div_pkg.sv | 28 ++
 rtl/div_step.sv | 29 ++
 rtl/div_unit.sv | 190 +++++++++++++++++++
 tb/tb_div_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle MIPS DIV/DIVU unit.
// Optional early-exit iteration skipping is enabled by defining DIV_EARLY_EXIT_EN.
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic [DIV_W-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } div_state_e;

  // Two's-complement negation when neg is set; also yields |x| from a signed operand.
  function automatic logic [DIV_W-1:0] div_neg_if(input logic [DIV_W-1:0] x, input logic neg);
    logic [DIV_W-1:0] r;
    if (neg) begin
      r = (~x) + 32'd1;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left by one and conditionally
// subtract the divisor magnitude from the partial remainder.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] rem_i,
  input  logic [DIV_W-1:0] quo_i,
  input  logic [DIV_W-1:0] dmag_i,
  output logic [DIV_W-1:0] rem_o,
  output logic [DIV_W-1:0] quo_o
);

  logic [DIV_W:0] sh_s;
  logic [DIV_W:0] t_s;

  // Trial subtract; bit DIV_W of the 33-bit difference is the borrow/sign.
  always_comb begin
    sh_s = {rem_i, quo_i[DIV_W-1]};
    t_s  = sh_s - {1'b0, dmag_i};
    if (t_s[DIV_W] == 1'b0) begin
      rem_o = t_s[DIV_W-1:0];
      quo_o = {quo_i[DIV_W-2:0], 1'b1};
    end else begin
      rem_o = sh_s[DIV_W-1:0];
      quo_o = {quo_i[DIV_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit MIPS DIV/DIVU producing HI (remainder) / LO (quotient).
// Define DIV_EARLY_EXIT_EN to skip iterations over the dividend's leading zeros.
module div_unit
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] clz_data,
  input  logic [DIV_W-1:0] clz_count,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] hi,
  output logic [DIV_W-1:0] lo
);

  div_state_e state_q, state_d;

  logic [DIV_W-1:0]     clz_data_q, clz_data_d;
  logic [DIV_W-1:0]     dmag_q, dmag_d;
  logic [DIV_W-1:0]     raw_q, raw_d;
  logic [DIV_W-1:0]     rem_q, rem_d;
  logic [DIV_W-1:0]     quo_q, quo_d;
  logic [DIV_W-1:0]     hi_q, hi_d;
  logic [DIV_W-1:0]     lo_q, lo_d;
  logic [DIV_CNT_W-1:0] iter_q, iter_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic                 signed_q, signed_d;
  logic                 nofix_q, nofix_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [DIV_W-1:0]     step_rem_s;
  logic [DIV_W-1:0]     step_quo_s;
  logic [DIV_CNT_W-1:0] skip_s;
  logic                 mag_zero_s;
  logic                 unused_clz_s;

`ifdef DIV_EARLY_EXIT_EN
  assign skip_s       = clz_count[DIV_CNT_W-1:0];
  assign mag_zero_s   = (clz_count[DIV_CNT_W-1:0] == 6'd32);
  assign unused_clz_s = ^clz_count[DIV_W-1:DIV_CNT_W];
`else
  assign skip_s       = 6'd0;
  assign mag_zero_s   = (clz_data_q == 32'd0);
  assign unused_clz_s = ^clz_count;
`endif

  div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dmag_i(dmag_q),
    .rem_o (step_rem_s),
    .quo_o (step_quo_s)
  );

  // Next-state and datapath control for IDLE -> PREP -> ITER -> FIX.
  always_comb begin
    state_d    = state_q;
    clz_data_d = clz_data_q;
    dmag_d     = dmag_q;
    raw_d      = raw_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    iter_d     = iter_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    signed_d   = signed_q;
    nofix_d    = nofix_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          clz_data_d = div_neg_if(dividend, is_signed & dividend[DIV_W-1]);
          dmag_d     = div_neg_if(divisor, is_signed & divisor[DIV_W-1]);
          raw_d      = dividend;
          sign_a_d   = dividend[DIV_W-1];
          sign_b_d   = divisor[DIV_W-1];
          signed_d   = is_signed;
          busy_d     = 1'b1;
          state_d    = PREP;
        end else begin
          state_d    = IDLE;
        end
      end

      PREP: begin
        if (dmag_q == 32'd0) begin
          quo_d   = DIV_ZERO_QUO;
          rem_d   = raw_q;
          nofix_d = 1'b1;
          state_d = FIX;
        end else if (mag_zero_s) begin
          quo_d   = 32'd0;
          rem_d   = 32'd0;
          nofix_d = 1'b0;
          state_d = FIX;
        end else begin
          // Pre-shifting past leading zeros lets the loop run only k = 32 - skip steps.
          rem_d   = 32'd0;
          quo_d   = clz_data_q << skip_s;
          iter_d  = 6'd32 - skip_s;
          nofix_d = 1'b0;
          state_d = ITER;
        end
      end

      ITER: begin
        rem_d  = step_rem_s;
        quo_d  = step_quo_s;
        iter_d = iter_q - 6'd1;
        if (iter_q == 6'd1) begin
          state_d = FIX;
        end else begin
          state_d = ITER;
        end
      end

      FIX: begin
        if (signed_q && !nofix_q) begin
          lo_d = div_neg_if(quo_q, sign_a_q ^ sign_b_q);
          hi_d = div_neg_if(rem_q, sign_a_q);
        end else begin
          lo_d = quo_q;
          hi_d = rem_q;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clz_data_q <= 32'd0;
      dmag_q     <= 32'd0;
      raw_q      <= 32'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      iter_q     <= 6'd0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      signed_q   <= 1'b0;
      nofix_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clz_data_q <= clz_data_d;
      dmag_q     <= dmag_d;
      raw_q      <= raw_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      iter_q     <= iter_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      signed_q   <= signed_d;
      nofix_q    <= nofix_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign clz_data = clz_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: transaction-level reference model plus
// directed literal cases and randomized operands.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic [31:0] clz_data;
  logic [31:0] clz_count;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  div_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .is_signed(is_signed),
    .dividend (dividend),
    .divisor  (divisor),
    .clz_data (clz_data),
    .clz_count(clz_count),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  function automatic int clz32(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) return c;
      c++;
    end
    return c;
  endfunction

  // Leading-zero counter that sits beside the divider in the real system.
  always_comb clz_count = 32'(clz32(clz_data));

  function automatic logic [31:0] mag_of(input logic [31:0] a, input logic s);
    logic [31:0] m;
    m = (s && a[31]) ? (32'd0 - a) : a;
    return m;
  endfunction

  // Returns {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!s) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Cycles from the start edge to the done cycle (done in cycle N+lat).
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] m;
    m = mag_of(a, s);
    if (b == 32'd0 || m == 32'd0) return 3;
`ifdef DIV_EARLY_EXIT_EN
    return 35 - clz32(m);
`else
    return 35;
`endif
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, advanced on every rising edge.
  int          cyc = 0;
  int          prev_cyc = 0;
  int          due = 0;
  bit          active = 1'b0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_clz = 32'd0;
  logic [31:0] p_hi = 32'd0;
  logic [31:0] p_lo = 32'd0;
  logic [63:0] m_res = 64'd0;

  always @(posedge clk) begin
    prev_cyc = cyc;
    cyc = cyc + 1;
    if (rst) begin
      active = 1'b0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      m_clz  = 32'd0;
    end else begin
      if (active && prev_cyc == due) active = 1'b0;
      if (start && !active) begin
        m_res  = ref_div(dividend, divisor, is_signed);
        p_hi   = m_res[63:32];
        p_lo   = m_res[31:0];
        m_clz  = mag_of(dividend, is_signed);
        due    = cyc + ref_lat(dividend, divisor, is_signed) - 1;
        active = 1'b1;
      end
      if (active && cyc == due) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    check32("done", 32'(done), 32'(active && cyc == due));
    check32("busy", 32'(busy), 32'(active && cyc < due));
    check32("hi", hi, m_hi);
    check32("lo", lo, m_lo);
    check32("clz_data", clz_data, m_clz);
  end

  // Called at a falling edge with the DUT idle; returns at the falling edge of the done cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] r_lo, output logic [31:0] r_hi, output int n);
    start = 1'b1;
    dividend = a;
    divisor = b;
    is_signed = s;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL timeout: no done after %0d cycles", n);
    end
    r_lo = lo;
    r_hi = hi;
  endtask

`ifdef DIV_EARLY_EXIT_EN
  localparam int LAT_100_7 = 10;
  localparam int LAT_M7_2  = 6;
`else
  localparam int LAT_100_7 = 35;
  localparam int LAT_M7_2  = 35;
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r_lo, r_hi, a, b;
    logic        s;
    int          n;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check32("reset_busy", 32'(busy), 32'd0);
    check32("reset_done", 32'(done), 32'd0);
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    check32("reset_clz", clz_data, 32'd0);

    do_op(32'd100, 32'd7, 1'b0, r_lo, r_hi, n);
    check32("u100_7_lo", r_lo, 32'd14);
    check32("u100_7_hi", r_hi, 32'd2);
    check32("u100_7_lat", 32'(n), 32'(LAT_100_7));

    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, r_lo, r_hi, n);
    check32("sm7_2_lo", r_lo, 32'hFFFF_FFFD);
    check32("sm7_2_hi", r_hi, 32'hFFFF_FFFF);
    check32("sm7_2_lat", 32'(n), 32'(LAT_M7_2));

    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, r_lo, r_hi, n);
    check32("smin_m1_lo", r_lo, 32'h8000_0000);
    check32("smin_m1_hi", r_hi, 32'd0);
    check32("smin_m1_lat", 32'(n), 32'd35);

    do_op(32'h1234_5678, 32'd0, 1'b0, r_lo, r_hi, n);
    check32("dz_lo", r_lo, 32'hFFFF_FFFF);
    check32("dz_hi", r_hi, 32'h1234_5678);
    check32("dz_lat", 32'(n), 32'd3);

    do_op(32'h8765_4321, 32'd0, 1'b1, r_lo, r_hi, n);
    check32("sdz_lo", r_lo, 32'hFFFF_FFFF);
    check32("sdz_hi", r_hi, 32'h8765_4321);
    check32("sdz_lat", 32'(n), 32'd3);

    do_op(32'd0, 32'd5, 1'b0, r_lo, r_hi, n);
    check32("zero5_lo", r_lo, 32'd0);
    check32("zero5_hi", r_hi, 32'd0);
    check32("zero5_lat", 32'(n), 32'd3);

    // start pulsed while the first divide is iterating must be ignored
    start = 1'b1;
    dividend = 32'd100;
    divisor = 32'd7;
    is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    repeat (4) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    dividend = 32'd7;
    divisor = 32'd1;
    @(negedge clk);
    start = 1'b0;
    n++;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check32("busy_start_lo", lo, 32'd14);
    check32("busy_start_hi", hi, 32'd2);
    check32("busy_start_lat", 32'(n), 32'(LAT_100_7));

    // reset during the 5th ITER cycle aborts without done
    start = 1'b1;
    dividend = 32'hFFFF_0000;
    divisor = 32'd3;
    is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check32("rst_mid_busy", 32'(busy), 32'd0);
    check32("rst_mid_done", 32'(done), 32'd0);
    check32("rst_mid_hi", hi, 32'd0);
    check32("rst_mid_lo", lo, 32'd0);
    repeat (3) @(negedge clk);

    do_op(32'd9, 32'd3, 1'b0, r_lo, r_hi, n);
    check32("u9_3_lo", r_lo, 32'd3);
    check32("u9_3_hi", r_hi, 32'd0);

    // randomized operands, often started in the done cycle of the previous op
    for (int i = 0; i < 50; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'd0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'($urandom_range(1, 15));
        4: a = 32'($urandom_range(0, 1000));
        5: b = {{16{b[15]}}, b[15:0]};
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      do_op(a, b, s, r_lo, r_hi, n);
      check32("rand_lat", 32'(n), 32'(ref_lat(a, b, s)));
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
